// File: rtl/ball_query_grouper.sv
// ============================================================================
// Module      : ball_query_grouper
// Description : Ball-query neighbour search; scans a point stream against a
//               centre point and emits up to K indices with dist^2 <= radius^2.
//               Optional macro GROUP_PAD_EN pads the output to exactly K beats.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ball_query_grouper #(
   parameter int COORD_W = 8,
   parameter int DIST_W  = 18,
   parameter int IDX_W   = 10,
   parameter int K       = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [COORD_W-1:0] cp_x,
   input  logic [COORD_W-1:0] cp_y,
   input  logic [COORD_W-1:0] cp_z,
   input  logic [DIST_W-1:0]  radius_sq,
   input  logic [IDX_W-1:0]   n_points,
   input  logic               pt_valid,
   output logic               pt_ready,
   input  logic [COORD_W-1:0] pt_x,
   input  logic [COORD_W-1:0] pt_y,
   input  logic [COORD_W-1:0] pt_z,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [IDX_W-1:0]   out_idx,
   output logic               out_last,
   output logic [IDX_W-1:0]   hit_count,
   output logic               busy,
   output logic               done
);

   localparam int              PTR_W = (K > 1) ? $clog2(K) : 1;
   localparam logic [IDX_W-1:0] C_K  = IDX_W'(K);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SCAN  = 2'd1,
      S_FLUSH = 2'd2,
      S_DRAIN = 2'd3
   } state_t;

   state_t r_state, w_next;

   logic [COORD_W-1:0] r_cp_x, r_cp_y, r_cp_z;
   logic [DIST_W-1:0]  r_radius;
   logic [IDX_W-1:0]   r_npts;
   logic [IDX_W-1:0]   r_accepted;
   logic [IDX_W-1:0]   r_hit_count;
   logic [IDX_W-1:0]   r_rd_ptr;
   logic               r_done;
   logic [IDX_W-1:0]   r_buf [K];

   logic               r_s1_valid;
   logic [COORD_W-1:0] r_dx, r_dy, r_dz;
   logic [IDX_W-1:0]   r_s1_idx;

   logic               w_pt_acc;
   logic               w_hit_full;
   logic [DIST_W-1:0]  w_dist;
   logic               w_hit;
   logic [IDX_W-1:0]   w_total;
   logic [IDX_W-1:0]   w_idx_sel;
   logic               w_out_hs;
   logic               w_drain_end;
   logic [COORD_W-1:0] w_adx, w_ady, w_adz;

   assign w_hit_full = (r_hit_count == C_K);
   assign pt_ready   = (r_state == S_SCAN) && (r_accepted < r_npts) && !w_hit_full;
   assign w_pt_acc   = pt_valid && pt_ready;

   assign w_adx = (pt_x >= r_cp_x) ? (pt_x - r_cp_x) : (r_cp_x - pt_x);
   assign w_ady = (pt_y >= r_cp_y) ? (pt_y - r_cp_y) : (r_cp_y - pt_y);
   assign w_adz = (pt_z >= r_cp_z) ? (pt_z - r_cp_z) : (r_cp_z - pt_z);

   // Squares are widened before multiplying so the sum never truncates.
   assign w_dist = DIST_W'(r_dx) * DIST_W'(r_dx)
                 + DIST_W'(r_dy) * DIST_W'(r_dy)
                 + DIST_W'(r_dz) * DIST_W'(r_dz);
   assign w_hit  = r_s1_valid && (w_dist <= r_radius) && !w_hit_full;

`ifdef GROUP_PAD_EN
   assign w_total   = C_K;
   assign w_idx_sel = (r_hit_count == '0)      ? '0 :
                      (r_rd_ptr < r_hit_count) ? r_buf[r_rd_ptr[PTR_W-1:0]] : r_buf[0];
`else
   assign w_total   = (r_hit_count == '0) ? IDX_W'(1) : r_hit_count;
   assign w_idx_sel = (r_hit_count == '0) ? '0 : r_buf[r_rd_ptr[PTR_W-1:0]];
`endif

   assign out_valid   = (r_state == S_DRAIN);
   assign out_idx     = out_valid ? w_idx_sel : '0;
   assign out_last    = out_valid && (r_rd_ptr == (w_total - IDX_W'(1)));
   assign w_out_hs    = out_valid && out_ready;
   assign w_drain_end = w_out_hs && out_last;
   assign hit_count   = r_hit_count;
   assign busy        = (r_state != S_IDLE);
   assign done        = r_done;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (start) w_next = (n_points == '0) ? S_FLUSH : S_SCAN;
         S_SCAN:  if ((r_accepted == r_npts) || w_hit_full) w_next = S_FLUSH;
         S_FLUSH: if (!r_s1_valid) w_next = S_DRAIN;
         S_DRAIN: if (w_drain_end) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cp_x      <= '0;
         r_cp_y      <= '0;
         r_cp_z      <= '0;
         r_radius    <= '0;
         r_npts      <= '0;
         r_accepted  <= '0;
         r_hit_count <= '0;
         r_rd_ptr    <= '0;
         r_done      <= 1'b0;
         r_s1_valid  <= 1'b0;
         r_dx        <= '0;
         r_dy        <= '0;
         r_dz        <= '0;
         r_s1_idx    <= '0;
         for (int i = 0; i < K; i++) r_buf[i] <= '0;
      end else begin
         if ((r_state == S_IDLE) && start) begin
            r_cp_x      <= cp_x;
            r_cp_y      <= cp_y;
            r_cp_z      <= cp_z;
            r_radius    <= radius_sq;
            r_npts      <= n_points;
            r_accepted  <= '0;
            r_hit_count <= '0;
            r_rd_ptr    <= '0;
         end else begin
            if (w_pt_acc) r_accepted <= r_accepted + IDX_W'(1);
            if (w_hit) begin
               r_buf[r_hit_count[PTR_W-1:0]] <= r_s1_idx;
               r_hit_count                   <= r_hit_count + IDX_W'(1);
            end
            if (w_out_hs) r_rd_ptr <= r_rd_ptr + IDX_W'(1);
         end
         r_s1_valid <= w_pt_acc;
         if (w_pt_acc) begin
            r_dx     <= w_adx;
            r_dy     <= w_ady;
            r_dz     <= w_adz;
            r_s1_idx <= r_accepted;
         end
         r_done <= w_drain_end;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_ball_query_grouper.sv
// ============================================================================
// Module      : tb_ball_query_grouper
// Description : Scoreboard bench for ball_query_grouper; directed queries.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ball_query_grouper;

   localparam int KK = 16;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [7:0] cp_x = '0, cp_y = '0, cp_z = '0;
   logic [17:0] radius_sq = '0;
   logic [9:0] n_points = '0;
   logic       pt_valid = 1'b0;
   logic       pt_ready;
   logic [7:0] pt_x = '0, pt_y = '0, pt_z = '0;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [9:0] out_idx;
   logic       out_last;
   logic [9:0] hit_count;
   logic       busy;
   logic       done;

   ball_query_grouper #(.COORD_W(8), .DIST_W(18), .IDX_W(10), .K(KK)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .cp_x(cp_x), .cp_y(cp_y), .cp_z(cp_z),
      .radius_sq(radius_sq), .n_points(n_points),
      .pt_valid(pt_valid), .pt_ready(pt_ready),
      .pt_x(pt_x), .pt_y(pt_y), .pt_z(pt_z),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_idx(out_idx), .out_last(out_last),
      .hit_count(hit_count), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct {
      int idx;
      bit last;
   } exp_t;

   exp_t q_exp[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   done_cnt = 0;
   int   m_hits, m_first, m_acc;
   int   m_cx, m_cy, m_cz, m_rad;

   task automatic check(input string nm, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Monitor: pops one expectation per output handshake and checks hold-stability.
   bit       prev_stall = 1'b0;
   int       prev_idx   = 0;
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check("stall_valid", int'(out_valid), 1);
            check("stall_idx", int'(out_idx), prev_idx);
         end
         if (out_valid && out_ready) begin
            if (q_exp.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_beat: got idx %0d expected no beat", out_idx);
            end else begin
               e = q_exp.pop_front();
               check("out_idx", int'(out_idx), e.idx);
               check("out_last", int'(out_last), int'(e.last));
            end
         end
         prev_stall = out_valid && !out_ready;
         prev_idx   = int'(out_idx);
         if (done) done_cnt++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_q(input int cx, input int cy, input int cz, input int rad, input int np);
      cp_x = 8'(cx); cp_y = 8'(cy); cp_z = 8'(cz);
      radius_sq = 18'(rad); n_points = 10'(np);
      m_cx = cx; m_cy = cy; m_cz = cz; m_rad = rad;
      m_hits = 0; m_first = 0; m_acc = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   function automatic int absd(input int a, input int b);
      return (a > b) ? a - b : b - a;
   endfunction

   task automatic feed(input int x, input int y, input int z, input int gap, output bit ok);
      int d;
      ok = 1'b0;
      pt_x = 8'(x); pt_y = 8'(y); pt_z = 8'(z);
      pt_valid = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (pt_ready) begin
            @(posedge clk);
            #1;
            ok = 1'b1;
            break;
         end
      end
      pt_valid = 1'b0;
      if (ok) begin
         d = absd(x, m_cx) ** 2 + absd(y, m_cy) ** 2 + absd(z, m_cz) ** 2;
         if (d <= m_rad && m_hits < KK) begin
            if (m_hits == 0) m_first = m_acc;
            q_exp.push_back('{idx: m_acc, last: 1'b0});
            m_hits++;
         end
         m_acc++;
         repeat (gap) tick();
      end
   endtask

   task automatic finalize();
`ifdef GROUP_PAD_EN
      for (int i = m_hits; i < KK; i++)
         q_exp.push_back('{idx: (m_hits == 0) ? 0 : m_first, last: 1'b0});
      q_exp[q_exp.size()-1].last = 1'b1;
`else
      if (m_hits == 0) q_exp.push_back('{idx: 0, last: 1'b1});
      else q_exp[q_exp.size()-1].last = 1'b1;
`endif
   endtask

   task automatic finish_q(input string nm, input int stall);
      int  base;
      bit  seen;
      base = done_cnt;
      seen = 1'b0;
      for (int c = 0; c < 200 && !out_valid; c++) tick();
      repeat (stall) tick();
      out_ready = 1'b1;
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         if (done) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s_timeout: got no done expected done within bound", nm);
      end
      out_ready = 1'b0;
      tick();
      tick();
      check({nm, "_done_once"}, done_cnt - base, 1);
      check({nm, "_hit_count"}, int'(hit_count), m_hits);
      check({nm, "_queue_empty"}, q_exp.size(), 0);
      check({nm, "_idle"}, int'(busy), 0);
      q_exp.delete();
   endtask

   initial begin
      bit ok;
      repeat (3) tick();
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_hit_count", int'(hit_count), 0);
      check("rst_pt_ready", int'(pt_ready), 0);
      rst_n = 1'b1;
      tick();

      // T1: four far-corner points, radius exactly at the maximum distance
      start_q(0, 0, 0, 195075, 4);
      for (int i = 0; i < 4; i++) feed(255, 255, 255, 0, ok);
      finalize();
      finish_q("t1", 0);

      // T2: distance 66624, just outside then exactly on the boundary
      start_q(11, 63, 255, 66623, 1);
      feed(195, 191, 127, 0, ok);
      finalize();
      finish_q("t2_miss", 0);
      start_q(11, 63, 255, 66624, 1);
      feed(195, 191, 127, 0, ok);
      finalize();
      finish_q("t2_hit", 0);

      // T3: every point hits; intake must close after K hits
      start_q(100, 100, 100, 0, 40);
      for (int i = 0; i < 40; i++) begin
         feed(100, 100, 100, 0, ok);
         if (!ok) break;
      end
      check("t3_pt_ready_low", int'(pt_ready), 0);
      check("t3_accepted_below_n", int'(m_acc < 40), 1);
      finalize();
      finish_q("t3", 0);

      // T4: gapped valid, mixed hits/misses, output stalled 5 cycles
      start_q(50, 50, 50, 100, 6);
      feed(50, 50, 50, 2, ok);
      feed(60, 50, 50, 1, ok);
      feed(61, 50, 50, 2, ok);
      feed(40, 45, 50, 0, ok);
      feed(45, 45, 45, 3, ok);
      feed(0, 0, 0, 1, ok);
      finalize();
      finish_q("t4", 5);

      // T5: empty query, with a start pulse that arrives while busy
      start_q(1, 2, 3, 1000, 0);
      tick();
      cp_x = 8'd9; n_points = 10'd5; radius_sq = 18'd0;
      start = 1'b1;
      tick();
      start = 1'b0;
      finalize();
      finish_q("t5", 2);

      // T6: asynchronous reset in the middle of a scan
      start_q(10, 10, 10, 500, 10);
      feed(10, 10, 10, 0, ok);
      feed(11, 11, 11, 0, ok);
      feed(12, 12, 12, 0, ok);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("t6_rst_busy", int'(busy), 0);
      check("t6_rst_valid", int'(out_valid), 0);
      check("t6_rst_hits", int'(hit_count), 0);
      check("t6_rst_ready", int'(pt_ready), 0);
      check("t6_rst_done", int'(done), 0);
      q_exp.delete();
      tick();
      rst_n = 1'b1;
      tick();
      start_q(5, 5, 5, 3, 3);
      feed(5, 5, 5, 0, ok);
      feed(9, 9, 9, 0, ok);
      feed(6, 6, 6, 0, ok);
      finalize();
      finish_q("t6_clean", 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
